// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port async data RAM: CPU port C has
// priority, DMA port D gets a starvation timer and short locked bursts.
module dmem_arbiter #(
   parameter int REG_WIDTH = 16,
   parameter int MAX_WAIT  = 4,
   parameter int BURST_MAX = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_wen,
   input  logic [REG_WIDTH-1:0] cpu_addr,
   input  logic [REG_WIDTH-1:0] cpu_din,
   output logic                 cpu_gnt,
   output logic                 cpu_stall,
   output logic [REG_WIDTH-1:0] cpu_dout,
   input  logic                 dma_req,
   input  logic                 dma_wen,
   input  logic                 dma_lock,
   input  logic [REG_WIDTH-1:0] dma_addr,
   input  logic [REG_WIDTH-1:0] dma_din,
   output logic                 dma_gnt,
   output logic [REG_WIDTH-1:0] dma_rdata,
   output logic                 dma_rvalid,
   output logic [REG_WIDTH-1:0] mem_addr,
   output logic [REG_WIDTH-1:0] mem_din,
   output logic                 mem_wen,
   input  logic [REG_WIDTH-1:0] mem_dout
);

   // state   | meaning
   // S_ARB   | normal arbitration, C first unless D has waited MAX_WAIT cycles
   // S_BURST | D holds the RAM while dma_req & dma_lock, up to BURST_MAX grants
   // S_YIELD | one fairness cycle after a full burst, C first, no re-lock
   typedef enum logic [1:0] {S_ARB, S_BURST, S_YIELD} state_t;

   localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
   localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

   state_t     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic [7:0] burst_cnt_q, burst_cnt_d;
   logic       gnt_c, gnt_d;

   always_comb begin
      gnt_c       = 1'b0;
      gnt_d       = 1'b0;
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         S_ARB: begin
            if (dma_req && (wait_cnt_q == MAX_WAIT_C)) gnt_d = 1'b1;
            else if (cpu_req)                          gnt_c = 1'b1;
            else if (dma_req)                          gnt_d = 1'b1;
            if (gnt_d && dma_lock) begin
               state_d     = S_BURST;
               burst_cnt_d = 8'd1;
            end
         end
         S_BURST: begin
            if (dma_req && dma_lock && (burst_cnt_q < BURST_MAX_C)) begin
               gnt_d       = 1'b1;
               burst_cnt_d = burst_cnt_q + 8'd1;
            end else begin
               // Leaving the burst never wastes the cycle if C is waiting.
               gnt_c       = cpu_req;
               burst_cnt_d = 8'd0;
               state_d     = (dma_req && dma_lock) ? S_YIELD : S_ARB;
            end
         end
         S_YIELD: begin
            if (cpu_req)      gnt_c = 1'b1;
            else if (dma_req) gnt_d = 1'b1;
            state_d     = S_ARB;
            burst_cnt_d = 8'd0;
         end
         default: begin
            state_d     = S_ARB;
            burst_cnt_d = 8'd0;
         end
      endcase
   end

   assign cpu_gnt   = gnt_c & ~rst;
   assign dma_gnt   = gnt_d & ~rst;
   assign cpu_stall = cpu_req & ~cpu_gnt;
   assign cpu_dout  = cpu_gnt ? mem_dout : '0;

   always_comb begin
      if ((state_q == S_YIELD) || !dma_req || dma_gnt) wait_cnt_d = 8'd0;
      else if (wait_cnt_q >= MAX_WAIT_C)               wait_cnt_d = MAX_WAIT_C;
      else                                             wait_cnt_d = wait_cnt_q + 8'd1;
   end

   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      mem_wen  = 1'b0;
      if (cpu_gnt) begin
         mem_addr = cpu_addr;
         mem_din  = cpu_din;
         mem_wen  = cpu_wen;
      end else if (dma_gnt) begin
         mem_addr = dma_addr;
         mem_din  = dma_din;
         mem_wen  = dma_wen;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_ARB;
         wait_cnt_q  <= 8'd0;
         burst_cnt_q <= 8'd0;
         dma_rdata   <= '0;
         dma_rvalid  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         dma_rvalid  <= dma_gnt & ~dma_wen;
         if (dma_gnt && !dma_wen) dma_rdata <= mem_dout;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural async RAM behind it.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_wen, cpu_gnt, cpu_stall;
   logic [15:0] cpu_addr, cpu_din, cpu_dout;
   logic        dma_req, dma_wen, dma_lock, dma_gnt, dma_rvalid;
   logic [15:0] dma_addr, dma_din, dma_rdata;
   logic [15:0] mem_addr, mem_din, mem_dout;
   logic        mem_wen;

   logic [15:0] ram [0:65535];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   assign mem_dout = ram[mem_addr];
   always @(posedge clk) if (mem_wen) ram[mem_addr] <= mem_din;

   dmem_arbiter #(.REG_WIDTH(16), .MAX_WAIT(4), .BURST_MAX(8)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_dout(cpu_dout),
      .dma_req(dma_req), .dma_wen(dma_wen), .dma_lock(dma_lock),
      .dma_addr(dma_addr), .dma_din(dma_din), .dma_gnt(dma_gnt),
      .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(mem_dout)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      @(negedge clk);
   endtask

   task automatic idle;
      cpu_req = 1'b0; cpu_wen = 1'b0; dma_req = 1'b0; dma_wen = 1'b0; dma_lock = 1'b0;
   endtask

   task automatic test_reset;
      cpu_req = 1'b1; dma_req = 1'b1; dma_wen = 1'b1; dma_addr = 16'h0040;
      repeat (2) @(posedge clk);
      settle;
      n_tests++;
      if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
         n_fail++; $display("FAIL rst_grants: cpu_gnt=%b dma_gnt=%b want 0 0", cpu_gnt, dma_gnt);
      end
      n_tests++;
      if (mem_wen !== 1'b0 || dma_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL rst_wen_rvalid: mem_wen=%b rvalid=%b want 0 0", mem_wen, dma_rvalid);
      end
      dma_req = 1'b0; dma_wen = 1'b0;
      tick;
      rst = 1'b0;
      settle;
      n_tests++;
      if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin
         n_fail++; $display("FAIL rst_release: cpu_gnt=%b stall=%b dma_gnt=%b want 1 0 0", cpu_gnt, cpu_stall, dma_gnt);
      end
      tick;
      idle;
      settle;
      n_tests++;
      if (mem_addr !== 16'h0 || mem_din !== 16'h0 || mem_wen !== 1'b0 || cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
         n_fail++; $display("FAIL idle: addr=%h din=%h wen=%b gc=%b gd=%b want all 0", mem_addr, mem_din, mem_wen, cpu_gnt, dma_gnt);
      end
   endtask

   task automatic test_cpu_access;
      tick;
      cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 16'h0010; cpu_din = 16'hBEEF;
      settle;
      n_tests++;
      if (mem_wen !== 1'b1 || mem_addr !== 16'h0010 || mem_din !== 16'hBEEF) begin
         n_fail++; $display("FAIL cpu_write: wen=%b addr=%h din=%h want 1 0010 beef", mem_wen, mem_addr, mem_din);
      end
      tick;
      cpu_addr = 16'h0020; cpu_din = 16'h1234;
      tick;
      cpu_wen = 1'b0;
      settle;
      n_tests++;
      if (cpu_dout !== 16'h1234 || mem_wen !== 1'b0) begin
         n_fail++; $display("FAIL cpu_read: dout=%h wen=%b want 1234 0", cpu_dout, mem_wen);
      end
      tick;
      idle;
      settle;
      n_tests++;
      if (cpu_dout !== 16'h0) begin
         n_fail++; $display("FAIL cpu_dout_idle: dout=%h want 0000", cpu_dout);
      end
   endtask

   task automatic test_dma_access;
      tick;
      dma_req = 1'b1; dma_wen = 1'b0; dma_addr = 16'h0010;
      settle;
      n_tests++;
      if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_addr !== 16'h0010) begin
         n_fail++; $display("FAIL dma_gnt: gd=%b gc=%b addr=%h want 1 0 0010", dma_gnt, cpu_gnt, mem_addr);
      end
      tick;
      dma_req = 1'b0;
      settle;
      n_tests++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== 16'hBEEF) begin
         n_fail++; $display("FAIL dma_read: rvalid=%b rdata=%h want 1 beef", dma_rvalid, dma_rdata);
      end
      tick;
      settle;
      n_tests++;
      if (dma_rvalid !== 1'b0 || dma_rdata !== 16'hBEEF) begin
         n_fail++; $display("FAIL dma_hold: rvalid=%b rdata=%h want 0 beef", dma_rvalid, dma_rdata);
      end
      tick;
      dma_req = 1'b1; dma_wen = 1'b1; dma_addr = 16'h0030; dma_din = 16'h5A5A;
      settle;
      n_tests++;
      if (dma_gnt !== 1'b1 || mem_wen !== 1'b1 || mem_din !== 16'h5A5A) begin
         n_fail++; $display("FAIL dma_write: gd=%b wen=%b din=%h want 1 1 5a5a", dma_gnt, mem_wen, mem_din);
      end
      tick;
      idle;
      cpu_req = 1'b1; cpu_addr = 16'h0030;
      settle;
      n_tests++;
      if (dma_rvalid !== 1'b0 || cpu_dout !== 16'h5A5A) begin
         n_fail++; $display("FAIL dma_write_rb: rvalid=%b dout=%h want 0 5a5a", dma_rvalid, cpu_dout);
      end
      tick;
      idle;
   endtask

   task automatic test_starvation;
      logic [5:0] exp_d;
      exp_d = 6'b010000;
      tick;
      cpu_req = 1'b1; cpu_addr = 16'h0020;
      dma_req = 1'b1; dma_wen = 1'b0; dma_lock = 1'b0; dma_addr = 16'h0010;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick;
         settle;
         n_tests++;
         if (dma_gnt !== exp_d[i] || cpu_gnt !== ~exp_d[i] || cpu_stall !== exp_d[i]) begin
            n_fail++; $display("FAIL starve_c%0d: gd=%b gc=%b stall=%b want %b %b %b",
                               i, dma_gnt, cpu_gnt, cpu_stall, exp_d[i], ~exp_d[i], exp_d[i]);
         end
      end
      n_tests++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== 16'hBEEF) begin
         n_fail++; $display("FAIL starve_read: rvalid=%b rdata=%h want 1 beef", dma_rvalid, dma_rdata);
      end
      tick;
      idle;
   endtask

   task automatic test_burst;
      logic [18:0] exp_d;
      exp_d = 19'b1000000111111110000;
      tick;
      cpu_req = 1'b1; cpu_addr = 16'h0020;
      dma_req = 1'b1; dma_wen = 1'b0; dma_lock = 1'b1; dma_addr = 16'h0010;
      for (int i = 0; i < 19; i++) begin
         if (i > 0) tick;
         settle;
         n_tests++;
         if (dma_gnt !== exp_d[i] || cpu_gnt !== ~exp_d[i]) begin
            n_fail++; $display("FAIL burst_c%0d: gd=%b gc=%b want %b %b", i, dma_gnt, cpu_gnt, exp_d[i], ~exp_d[i]);
         end
      end
      tick;
      idle;
      settle;
      n_tests++;
      if (dma_gnt !== 1'b0 || cpu_gnt !== 1'b0) begin
         n_fail++; $display("FAIL burst_exit_idle: gd=%b gc=%b want 0 0", dma_gnt, cpu_gnt);
      end
   endtask

   task automatic test_lock_drop;
      logic [14:0] exp_d, c_req;
      exp_d = 15'b110111111110111;
      c_req = 15'b000000000001000;
      tick;
      dma_req = 1'b1; dma_wen = 1'b1; dma_addr = 16'h0050; dma_din = 16'h0001;
      cpu_addr = 16'h0020;
      for (int i = 0; i < 15; i++) begin
         if (i > 0) tick;
         cpu_req  = c_req[i];
         dma_lock = ~c_req[i];
         settle;
         n_tests++;
         if (dma_gnt !== exp_d[i] || cpu_gnt !== c_req[i]) begin
            n_fail++; $display("FAIL lockdrop_c%0d: gd=%b gc=%b want %b %b", i, dma_gnt, cpu_gnt, exp_d[i], c_req[i]);
         end
      end
      tick;
      idle;
   endtask

   task automatic test_reset_mid_burst;
      logic [4:0] exp_d;
      exp_d = 5'b10000;
      tick;
      dma_req = 1'b1; dma_wen = 1'b0; dma_lock = 1'b1; dma_addr = 16'h0010;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) tick;
         settle;
         n_tests++;
         if (dma_gnt !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre%0d: gd=%b want 1", i, dma_gnt);
         end
      end
      tick;
      rst = 1'b1;
      settle;
      n_tests++;
      if (dma_gnt !== 1'b0 || cpu_gnt !== 1'b0 || dma_rvalid !== 1'b0 || mem_wen !== 1'b0) begin
         n_fail++; $display("FAIL midrst_cut: gd=%b gc=%b rvalid=%b wen=%b want 0 0 0 0", dma_gnt, cpu_gnt, dma_rvalid, mem_wen);
      end
      tick;
      rst = 1'b0;
      cpu_req = 1'b1; cpu_addr = 16'h0020; dma_lock = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick;
         settle;
         n_tests++;
         if (dma_gnt !== exp_d[i] || cpu_gnt !== ~exp_d[i] || (i == 0 && dma_rvalid !== 1'b0)) begin
            n_fail++; $display("FAIL midrst_post%0d: gd=%b gc=%b rvalid=%b want %b %b 0",
                               i, dma_gnt, cpu_gnt, dma_rvalid, exp_d[i], ~exp_d[i]);
         end
      end
      tick;
      idle;
   endtask

   initial begin
      rst = 1'b1;
      idle;
      cpu_addr = '0; cpu_din = '0; dma_addr = '0; dma_din = '0;
      test_reset;
      test_cpu_access;
      test_dma_access;
      test_starvation;
      test_burst;
      test_lock_drop;
      test_reset_mid_burst;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
